// File: rtl/pixel_mem_engine_pkg.sv
// Shared opcodes, FSM states and instruction field offsets for pixel_mem_engine.
// Optional clipping is enabled in the top by defining PIXEL_MEM_ENGINE_CLIP_EN.
package pixel_mem_engine_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PLOT  = 4'd1;
    localparam logic [3:0] OP_READ  = 4'd2;
    localparam logic [3:0] OP_WRITE = 4'd3;
    localparam logic [3:0] OP_RECT  = 4'd4;

    typedef enum logic [2:0] {
        StIdle,
        StExecPlot,
        StRdWait,
        StWr,
        StRect,
        StDone
    } state_e;

    // Pixel op layout, LSB first: x0, y0, colour, w, h.
    function automatic int unsigned y_lsb(input int unsigned x_w);
        return x_w;
    endfunction

    function automatic int unsigned col_lsb(input int unsigned x_w, input int unsigned y_w);
        return x_w + y_w;
    endfunction

    function automatic int unsigned w_lsb(input int unsigned x_w, input int unsigned y_w,
                                          input int unsigned col_w);
        return x_w + y_w + col_w;
    endfunction

    function automatic int unsigned h_lsb(input int unsigned x_w, input int unsigned y_w,
                                          input int unsigned col_w);
        return 2 * x_w + y_w + col_w;
    endfunction

    // Memory op layout, LSB first: address, data.
    function automatic int unsigned data_lsb(input int unsigned addr_w);
        return addr_w;
    endfunction

endpackage

// File: rtl/pixel_mem_engine_rect_scanner.sv
// Column/row raster counter: walks w*h positions, column inner, one per clock.
// col/row hold the last position after the scan so downstream coordinates persist.
module pixel_mem_engine_rect_scanner
    import pixel_mem_engine_pkg::*;
#(
    parameter int unsigned X_W = 8,
    parameter int unsigned Y_W = 7
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    output logic [X_W-1:0] col,
    output logic [Y_W-1:0] row,
    output logic           valid,
    output logic           last
);

    logic [X_W-1:0] w_q, w_d, col_q, col_d;
    logic [Y_W-1:0] h_q, h_d, row_q, row_d;
    logic           valid_q, valid_d;
    logic           col_end, row_end;

    assign col_end = (col_q == w_q - X_W'(1));
    assign row_end = (row_q == h_q - Y_W'(1));

    always_comb begin
        w_d     = w_q;
        h_d     = h_q;
        col_d   = col_q;
        row_d   = row_q;
        valid_d = valid_q;
        if (start) begin
            w_d     = w;
            h_d     = h;
            col_d   = '0;
            row_d   = '0;
            valid_d = (w != '0) && (h != '0);
        end else if (valid_q) begin
            if (col_end && row_end) begin
                valid_d = 1'b0;
            end else if (col_end) begin
                col_d = '0;
                row_d = row_q + Y_W'(1);
            end else begin
                col_d = col_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_q     <= '0;
            h_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            w_q     <= w_d;
            h_q     <= h_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
        end
    end

    assign col   = col_q;
    assign row   = row_q;
    assign valid = valid_q;
    assign last  = valid_q && col_end && row_end;

endmodule

// File: rtl/pixel_mem_engine.sv
// Single-instruction executor for pixel plots, filled rectangles and memory read/write.
// Define PIXEL_MEM_ENGINE_CLIP_EN to suppress pixels outside SCREEN_W x SCREEN_H.
module pixel_mem_engine
    import pixel_mem_engine_pkg::*;
#(
    parameter int unsigned X_W        = 8,
    parameter int unsigned Y_W        = 7,
    parameter int unsigned COL_W      = 3,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned INSTR_W    = 40,
    parameter int unsigned MEM_RD_LAT = 2,
    parameter int unsigned SCREEN_W   = 160,
    parameter int unsigned SCREEN_H   = 120
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instruction,
    output logic               ready,
    output logic               done,
    output logic               error,
    output logic [DATA_W-1:0]  result,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COL_W-1:0]   colour,
    output logic               plot,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [DATA_W-1:0]  mem_data,
    output logic               mem_write,
    input  logic [DATA_W-1:0]  mem_output
);

    localparam int unsigned YLsb    = y_lsb(X_W);
    localparam int unsigned ColLsb  = col_lsb(X_W, Y_W);
    localparam int unsigned WLsb    = w_lsb(X_W, Y_W, COL_W);
    localparam int unsigned HLsb    = h_lsb(X_W, Y_W, COL_W);
    localparam int unsigned DataLsb = data_lsb(ADDR_W);
    localparam int unsigned CntW    = $clog2(MEM_RD_LAT + 1);

    logic [3:0]        in_op;
    logic [X_W-1:0]    in_x0, in_w;
    logic [Y_W-1:0]    in_y0, in_h;
    logic [COL_W-1:0]  in_col;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;

    assign in_op   = instruction[INSTR_W-1 -: 4];
    assign in_x0   = instruction[0 +: X_W];
    assign in_y0   = instruction[YLsb +: Y_W];
    assign in_col  = instruction[ColLsb +: COL_W];
    assign in_w    = instruction[WLsb +: X_W];
    assign in_h    = instruction[HLsb +: Y_W];
    assign in_addr = instruction[0 +: ADDR_W];
    assign in_data = instruction[DataLsb +: DATA_W];

    logic unused_instr;
    assign unused_instr = ^instruction;

    state_e            state_q, state_d;
    logic              ready_q, ready_d, done_q, done_d, error_q, error_d;
    logic [DATA_W-1:0] result_q, result_d, mem_data_q, mem_data_d;
    logic [X_W-1:0]    x0_q, x0_d;
    logic [Y_W-1:0]    y0_q, y0_d;
    logic [COL_W-1:0]  colour_q, colour_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              mem_write_q, mem_write_d;
    logic [CntW-1:0]   rd_cnt_q, rd_cnt_d;

    logic              accept;
    logic              scan_start, scan_valid, scan_last;
    logic [X_W-1:0]    scan_w, scan_col;
    logic [Y_W-1:0]    scan_h, scan_row;

    assign accept = start && ready_q;

    always_comb begin
        state_d       = state_q;
        error_d       = error_q;
        result_d      = result_q;
        x0_d          = x0_q;
        y0_d          = y0_q;
        colour_d      = colour_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_write_d   = 1'b0;
        rd_cnt_d      = rd_cnt_q;
        scan_start    = 1'b0;
        scan_w        = in_w;
        scan_h        = in_h;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    error_d = 1'b0;
                    case (in_op)
                        OP_NOP: state_d = StDone;
                        OP_PLOT: begin
                            x0_d       = in_x0;
                            y0_d       = in_y0;
                            colour_d   = in_col;
                            scan_start = 1'b1;
                            scan_w     = X_W'(1);
                            scan_h     = Y_W'(1);
                            state_d    = StExecPlot;
                        end
                        OP_READ: begin
                            mem_address_d = in_addr;
                            rd_cnt_d      = CntW'(1);
                            state_d       = StRdWait;
                        end
                        OP_WRITE: begin
                            mem_address_d = in_addr;
                            mem_data_d    = in_data;
                            mem_write_d   = 1'b1;
                            state_d       = StWr;
                        end
                        OP_RECT: begin
                            // Empty rectangles finish at once and leave x/y/colour untouched.
                            if (in_w != '0 && in_h != '0) begin
                                x0_d       = in_x0;
                                y0_d       = in_y0;
                                colour_d   = in_col;
                                scan_start = 1'b1;
                                state_d    = StRect;
                            end else begin
                                state_d = StDone;
                            end
                        end
                        default: begin
                            error_d = 1'b1;
                            state_d = StDone;
                        end
                    endcase
                end
            end
            StExecPlot, StRect: begin
                if (scan_last) state_d = StDone;
            end
            StRdWait: begin
                if (rd_cnt_q == CntW'(MEM_RD_LAT)) begin
                    result_d = mem_output;
                    state_d  = StDone;
                end else begin
                    rd_cnt_d = rd_cnt_q + CntW'(1);
                end
            end
            StWr:    state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    assign done_d  = (state_d == StDone);
    assign ready_d = (state_d == StIdle) || (state_d == StDone);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            result_q      <= '0;
            x0_q          <= '0;
            y0_q          <= '0;
            colour_q      <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_write_q   <= 1'b0;
            rd_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
            error_q       <= error_d;
            result_q      <= result_d;
            x0_q          <= x0_d;
            y0_q          <= y0_d;
            colour_q      <= colour_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_write_q   <= mem_write_d;
            rd_cnt_q      <= rd_cnt_d;
        end
    end

    pixel_mem_engine_rect_scanner #(
        .X_W(X_W),
        .Y_W(Y_W)
    ) u_scanner (
        .clock(clock),
        .reset(reset),
        .start(scan_start),
        .w    (scan_w),
        .h    (scan_h),
        .col  (scan_col),
        .row  (scan_row),
        .valid(scan_valid),
        .last (scan_last)
    );

    logic in_bounds;

`ifdef PIXEL_MEM_ENGINE_CLIP_EN
    localparam logic [X_W:0] XLim = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0] YLim = (Y_W + 1)'(SCREEN_H);
    logic [X_W:0] x_sum;
    logic [Y_W:0] y_sum;
    // One extra bit so coordinates past the edge compare as large instead of wrapping.
    assign x_sum     = {1'b0, x0_q} + {1'b0, scan_col};
    assign y_sum     = {1'b0, y0_q} + {1'b0, scan_row};
    assign in_bounds = (x_sum < XLim) && (y_sum < YLim);
`else
    logic unused_screen;
    assign unused_screen = (SCREEN_W == 0) ^ (SCREEN_H == 0);
    assign in_bounds     = 1'b1;
`endif

    assign ready       = ready_q;
    assign done        = done_q;
    assign error       = error_q;
    assign result      = result_q;
    assign x           = x0_q + scan_col;
    assign y           = y0_q + scan_row;
    assign colour      = colour_q;
    assign plot        = scan_valid && in_bounds;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_write   = mem_write_q;

endmodule

// File: tb/tb_pixel_mem_engine.sv
// Directed bench for pixel_mem_engine with a pixel scoreboard and a latency-2 memory model.
module tb_pixel_mem_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [39:0] instruction;
    logic        ready, done, error, plot, mem_write;
    logic [11:0] result, mem_data, mem_output;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic [15:0] mem_address;

    int n_checks = 0;
    int n_errors = 0;

    logic [17:0] pix_q[$];
    logic [11:0] mem[256];
    logic [11:0] rd_q;

    always #5 clock = ~clock;

    pixel_mem_engine dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .instruction(instruction),
        .ready      (ready),
        .done       (done),
        .error      (error),
        .result     (result),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_write  (mem_write),
        .mem_output (mem_output)
    );

    // Data for the address presented in cycle k is valid during cycle k+1.
    always @(posedge clock) begin
        if (mem_write) mem[mem_address[7:0]] <= mem_data;
        rd_q <= mem[mem_address[7:0]];
    end
    assign mem_output = rd_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0 && plot === 1'b1) begin
            n_checks++;
            assert (pix_q.size() != 0)
            else begin
                n_errors++;
                $error("FAIL extra_plot: got plot=1 at (%0d,%0d), expected no plot", x, y);
            end
            if (pix_q.size() != 0) chk("pixel_xyc", {14'd0, x, y, colour}, {14'd0, pix_q.pop_front()});
        end
    end

    function automatic logic [39:0] pix_ins(input logic [3:0] op, input logic [7:0] x0,
                                            input logic [6:0] y0, input logic [2:0] c,
                                            input logic [7:0] w, input logic [6:0] h);
        logic [39:0] r;
        r = '0;
        r[39:36] = op;
        r[7:0]   = x0;
        r[14:8]  = y0;
        r[17:15] = c;
        r[25:18] = w;
        r[32:26] = h;
        return r;
    endfunction

    function automatic logic [39:0] mem_ins(input logic [3:0] op, input logic [15:0] addr,
                                            input logic [11:0] data);
        logic [39:0] r;
        r = '0;
        r[39:36] = op;
        r[15:0]  = addr;
        r[27:16] = data;
        return r;
    endfunction

    task automatic push_rect(input int x0, input int y0, input int c, input int w, input int h);
        for (int r = 0; r < h; r++) begin
            for (int cc = 0; cc < w; cc++) begin
                int xs;
                int ys;
                xs = x0 + cc;
                ys = y0 + r;
`ifdef PIXEL_MEM_ENGINE_CLIP_EN
                if (xs >= 160 || ys >= 120) continue;
`endif
                pix_q.push_back({8'(xs), 7'(ys), 3'(c)});
            end
        end
    endtask

    // Issues one instruction and waits (bounded) for done; cycle 1 is the cycle after accept.
    task automatic run(input string tag, input logic [39:0] ins, input int exp_done,
                       input bit b2b, input bit hold, output int wr_cycles);
        int cyc;
        bit seen;
        if (!b2b) @(negedge clock);
        start       = 1'b1;
        instruction = ins;
        @(posedge clock);
        #1 start = hold;
        cyc       = 0;
        seen      = 1'b0;
        wr_cycles = 0;
        while (!seen && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (mem_write) wr_cycles++;
            if (cyc == 1 && exp_done > 1) chk({tag, "_ready_low"}, {31'd0, ready}, 32'd0);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, seen ? cyc : 999, exp_done);
        chk({tag, "_ready_at_done"}, {31'd0, ready}, 32'd1);
        chk({tag, "_pixels_left"}, pix_q.size(), 32'd0);
    endtask

    initial begin
        int wr;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        reset       = 1'b1;
        start       = 1'b0;
        instruction = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_plot", {31'd0, plot}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_result", {20'd0, result}, 32'd0);
        chk("rst_xy", {17'd0, x, y}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_address}, 32'd0);

        push_rect(5, 7, 3, 1, 1);
        run("plot", pix_ins(4'd1, 8'd5, 7'd7, 3'd3, 8'd0, 7'd0), 2, 1'b0, 1'b0, wr);
        chk("plot_off_at_done", {31'd0, plot}, 32'd0);
        chk("plot_hold_xyc", {14'd0, x, y, colour}, {14'd0, 8'd5, 7'd7, 3'd3});

        run("write", mem_ins(4'd3, 16'h0010, 12'hABC), 2, 1'b0, 1'b0, wr);
        chk("write_strobe_cycles", wr, 32'd1);
        chk("write_addr_hold", {16'd0, mem_address}, 32'h0010);
        chk("write_data_hold", {20'd0, mem_data}, 32'hABC);

        run("read", mem_ins(4'd2, 16'h0010, 12'h000), 3, 1'b1, 1'b0, wr);
        chk("read_result", {20'd0, result}, 32'hABC);
        chk("read_no_write", wr, 32'd0);

        run("write2", mem_ins(4'd3, 16'h0020, 12'h123), 2, 1'b0, 1'b0, wr);
        run("read2", mem_ins(4'd2, 16'h0020, 12'h000), 3, 1'b0, 1'b0, wr);
        chk("read2_result", {20'd0, result}, 32'h123);

        push_rect(10, 20, 6, 3, 2);
        run("rect3x2", pix_ins(4'd4, 8'd10, 7'd20, 3'd6, 8'd3, 7'd2), 7, 1'b0, 1'b0, wr);
        chk("rect_result_hold", {20'd0, result}, 32'h123);

        run("rect_w0", pix_ins(4'd4, 8'd40, 7'd40, 3'd1, 8'd0, 7'd5), 1, 1'b0, 1'b0, wr);

        push_rect(254, 1, 2, 4, 1);
        run("rect_wrap", pix_ins(4'd4, 8'd254, 7'd1, 3'd2, 8'd4, 7'd1), 5, 1'b0, 1'b0, wr);

        push_rect(158, 3, 5, 4, 1);
        run("rect_edge", pix_ins(4'd4, 8'd158, 7'd3, 3'd5, 8'd4, 7'd1), 5, 1'b0, 1'b0, wr);

        run("illegal", pix_ins(4'd9, 8'd0, 7'd0, 3'd0, 8'd0, 7'd0), 1, 1'b0, 1'b0, wr);
        chk("illegal_error", {31'd0, error}, 32'd1);
        run("nop", pix_ins(4'd0, 8'd0, 7'd0, 3'd0, 8'd0, 7'd0), 1, 1'b0, 1'b0, wr);
        chk("nop_clears_error", {31'd0, error}, 32'd0);

        push_rect(30, 40, 4, 2, 2);
        run("rect_hold", pix_ins(4'd4, 8'd30, 7'd40, 3'd4, 8'd2, 7'd2), 5, 1'b0, 1'b1, wr);
        @(negedge clock);
        chk("hold_no_reaccept_done", {31'd0, done}, 32'd0);
        chk("hold_no_reaccept_ready", {31'd0, ready}, 32'd1);

        // Reset lands in cycle 3 of a 6-pixel rectangle.
        push_rect(10, 20, 1, 3, 2);
        @(negedge clock);
        start       = 1'b1;
        instruction = pix_ins(4'd4, 8'd10, 7'd20, 3'd1, 8'd3, 7'd2);
        @(posedge clock);
        #1 start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("abort_plot", {31'd0, plot}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_pixels_seen", pix_q.size(), 32'd4);
        pix_q.delete();
        repeat (2) begin
            @(negedge clock);
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clock);
        chk("post_abort_done", {31'd0, done}, 32'd0);
        chk("post_abort_plot", {31'd0, plot}, 32'd0);

        push_rect(1, 2, 5, 1, 1);
        run("plot_after_abort", pix_ins(4'd1, 8'd1, 7'd2, 3'd5, 8'd0, 7'd0), 2, 1'b0, 1'b0, wr);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pixel_mem_engine.md
Name: pixel_mem_engine

Overview:
- Parametrised next-generation single-instruction executor between the instruction sequencer and the VGA plotter / shared memory port.
- Accepts one instruction per start/ready handshake and executes it:
  - single-pixel plot
  - filled-rectangle raster plot
  - memory read with configurable latency
  - memory write
- Signals completion with a one-cycle done pulse.
- Flags illegal opcodes.

Parameters:
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COL_W, 3, colour width
- ADDR_W, 16, memory address width
- DATA_W, 12, memory data width
- INSTR_W, 40, instruction width; opcode is the top 4 bits
- MEM_RD_LAT, 2, memory read latency in clocks (≥1)
- SCREEN_W, 160, visible width (used only with clipping)
- SCREEN_H, 120, visible height (used only with clipping)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while ready=1
- instruction  in  INSTR_W  instruction word, captured on accept
- ready  out  1  engine idle, can accept
- done  out  1  one-cycle completion pulse
- error  out  1  last instruction had an illegal opcode
- result  out  DATA_W  last read data
- x  out  X_W  pixel x
- y  out  Y_W  pixel y
- colour  out  COL_W  pixel colour
- plot  out  1  pixel strobe
- mem_address  out  ADDR_W  memory address
- mem_data  out  DATA_W  write data
- mem_write  out  1  write strobe
- mem_output  in  DATA_W  read data

Behaviour:
- Interface (decided): one clock, clock; reset is asynchronous and active-high, named reset.
- Reset values:
  - ready=1; all other outputs 0.
  - Asserting reset mid-operation aborts immediately: plot and mem_write drop, no done pulse.
- Instruction fields:
  - opcode = instruction[INSTR_W-1:INSTR_W-4].
  - Pixel ops: x0=[X_W-1:0]; y0=[X_W+Y_W-1:X_W]; colour next COL_W bits; w next X_W bits; h next Y_W bits.
  - Memory ops: addr=[ADDR_W-1:0]; data=[ADDR_W+DATA_W-1:ADDR_W].
- Handshake:
  - Accept on the edge where start&ready=1 (edge 0); the instruction is latched and ready falls in cycle 1.
  - start while busy is ignored.
  - done and ready go high together in the completion cycle; a start in that cycle is accepted.
- Opcodes (cycle numbers count from the accept edge):
  - 0 NOP: done in cycle 1.
  - 1 PLOT: x/y/colour driven and plot=1 in cycle 1; done in cycle 2.
  - 2 READ: mem_address=addr, mem_write=0 from cycle 1; mem_output sampled at the end of cycle MEM_RD_LAT; result updated and done in cycle MEM_RD_LAT+1.
  - 3 WRITE: address/data driven and mem_write=1 for exactly cycle 1; done in cycle 2.
  - 4 RECT: N=w*h pixels, one per cycle in raster order (column inner, row outer). Pixel i appears in cycle 1+i with x=x0+col and y=y0+row, truncated to X_W/Y_W (wrap-around). done in cycle N+1; w=0 or h=0 gives done in cycle 1 with no plot.
  - 5–15: illegal. error=1 and done in cycle 1.
- error clears on the next accept.
- result holds its value until the next READ completes.
- x/y/colour/mem_address/mem_data hold their last values after completion; plot and mem_write are strobes only.
- State machine: IDLE → EXEC_PLOT | RD_WAIT | WR | RECT → DONE → IDLE.
  - NOP and illegal opcodes go directly to DONE.
  - DONE lasts one cycle and drives done=ready=1.
  - Start in DONE goes to the next exec state directly, skipping IDLE.
- RECT counters: col is X_W bits, row is Y_W bits. Last pixel is col=w-1 and row=h-1.

Optional Feature:
- Macro: PIXEL_MEM_ENGINE_CLIP_EN.
- With it: any pixel where x0+col ≥ SCREEN_W or y0+row ≥ SCREEN_H is suppressed.
  - Comparison uses X_W+1 / Y_W+1-bit sums, so there is no wrap.
  - plot=0 in that cycle; timing and done cycle are unchanged.
- Without it: all pixels are emitted with wrapped coordinates.

Decomposition:
- Shared package holds:
  - opcode localparams (OP_NOP…OP_RECT)
  - state enum
  - field-offset functions derived from X_W/Y_W/COL_W/ADDR_W/DATA_W
- One natural sub-module: rect_scanner, the col/row counter pair.
  - Inputs: start, w, h.
  - Outputs: col, row, valid, last.
  - Also used by PLOT with w=h=1.

Test Plan:
- PLOT with x0=5, y0=7, colour=3 → plot=1 only in cycle 1 with x=5, y=7, colour=3; done in cycle 2.
- WRITE addr=0x0010, data=0xABC, then READ addr=0x0010 with memory model latency 2 → mem_write high 1 cycle; READ gives result=0xABC with done in cycle 3.
- RECT x0=10, y0=20, w=3, h=2 → 6 plot cycles in order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); done in cycle 7. Also w=0 → done in cycle 1, no plot.
- RECT x0=254, w=4: without clipping x wraps to 254,255,0,1. With clipping (SCREEN_W=160, x0=158, w=4) only x=158,159 plot; done cycle unchanged.
- Opcode 9 → error=1 and done in cycle 1. Next NOP clears error. start held high while busy → no second accept.
- Reset asserted in cycle 3 of a 6-pixel RECT → plot=0 asynchronously, ready=1, no done; fresh PLOT then executes normally.
